// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the FIFO write arbiter.
package fifo_arb_pkg;

  // Write-side arbitration state: free to pick, or held by one producer mid-burst.
  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  // Occupancy counter width: must represent 0..depth inclusive.
  function automatic int lvl_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// Round-robin picker: first asserted request at or above ptr, wrapping modulo NREQ.
module rr_picker #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx,
  output logic            any
);

  // Scan offsets from the far end down so the closest request to ptr wins last.
  always_comb begin
    int j;
    j     = 0;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % NREQ;
      if (req[j]) begin
        idx = IDW'(j);
        any = 1'b1;
      end
    end
    if (any) grant[idx] = 1'b1;
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-locked write arbiter in front of a shared FIFO, with
// occupancy tracking and a zero-latency valid/ready read port.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int NREQ     = 4,
  parameter  int DWIDTH   = 32,
  parameter  int DEPTH    = 4,
  parameter  int AF_LEVEL = 3,
  localparam int IDW      = $clog2(NREQ),
  localparam int LW       = lvl_width(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        s_valid,
  input  logic [NREQ-1:0]        s_last,
  input  logic [NREQ*DWIDTH-1:0] s_data,
  output logic [NREQ-1:0]        s_ready,
  output logic                   fifo_wren,
  output logic [IDW+DWIDTH-1:0]  fifo_wd,
  input  logic                   fifo_full,
  input  logic                   fifo_empty,
  input  logic [IDW+DWIDTH-1:0]  fifo_rd,
  output logic                   fifo_rden,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [DWIDTH-1:0]      m_data,
  output logic [IDW-1:0]         m_id,
  output logic [LW-1:0]          level,
  output logic                   almost_full
);

  arb_state_e      state, state_nxt;
  logic [IDW-1:0]  rr_ptr, rr_ptr_nxt;
  logic [IDW-1:0]  owner, owner_nxt;
  logic [IDW-1:0]  sel;
  logic [NREQ-1:0] pick_grant;
  logic [IDW-1:0]  pick_idx;
  logic            pick_any;

  rr_picker #(.NREQ(NREQ), .IDW(IDW)) u_picker (
    .req   (s_valid),
    .ptr   (rr_ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // Arbitration state, round-robin pointer and burst owner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      rr_ptr <= '0;
      owner  <= '0;
    end else begin
      state  <= state_nxt;
      rr_ptr <= rr_ptr_nxt;
      owner  <= owner_nxt;
    end
  end

  // Grant decision; a full FIFO blocks writes even if a read frees a slot this cycle.
  always_comb begin
    state_nxt  = state;
    rr_ptr_nxt = rr_ptr;
    owner_nxt  = owner;
    sel        = owner;
    s_ready    = '0;
    fifo_wren  = 1'b0;
    if (rst_n && !fifo_full) begin
      unique case (state)
        IDLE: begin
          if (pick_any) begin
            sel        = pick_idx;
            s_ready    = pick_grant;
            fifo_wren  = 1'b1;
            rr_ptr_nxt = (pick_idx == IDW'(NREQ - 1)) ? '0 : pick_idx + IDW'(1);
            if (!s_last[pick_idx]) begin
              state_nxt = LOCKED;
              owner_nxt = pick_idx;
            end
          end
        end
        LOCKED: begin
          if (s_valid[owner]) begin
            s_ready[owner] = 1'b1;
            fifo_wren      = 1'b1;
            if (s_last[owner]) state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign fifo_wd = {sel, s_data[sel*DWIDTH +: DWIDTH]};

  assign m_valid   = !fifo_empty;
  assign fifo_rden = m_valid && m_ready;
  assign {m_id, m_data} = fifo_rd;

  // Occupancy: simultaneous write and read cancel out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level <= '0;
    end else if (fifo_wren && !fifo_rden) begin
      level <= level + LW'(1);
    end else if (!fifo_wren && fifo_rden) begin
      level <= level - LW'(1);
    end
  end

  assign almost_full = (level >= LW'(AF_LEVEL));

  a_level_max : assert property (@(posedge clk) disable iff (!rst_n) level <= LW'(DEPTH));
  a_empty     : assert property (@(posedge clk) disable iff (!rst_n) (level == '0) == fifo_empty);
  a_full      : assert property (@(posedge clk) disable iff (!rst_n) (level == LW'(DEPTH)) == fifo_full);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: behavioural FIFO attached, table-driven cycle vectors,
// scoreboard of expected {id,data} words checked as the consumer reads them.
module tb_fifo_wr_arbiter;

  localparam int NREQ  = 4;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int AF    = 3;
  localparam int IDW   = 2;
  localparam int LW    = 3;

  logic                 clk;
  logic                 rst_n;
  logic [NREQ-1:0]      s_valid, s_last, s_ready;
  logic [NREQ*DW-1:0]   s_data;
  logic                 fifo_wren, fifo_full, fifo_empty, fifo_rden;
  logic [IDW+DW-1:0]    fifo_wd, fifo_rd;
  logic                 m_valid, m_ready, almost_full;
  logic [DW-1:0]        m_data;
  logic [IDW-1:0]       m_id;
  logic [LW-1:0]        level;

  fifo_wr_arbiter #(.NREQ(NREQ), .DWIDTH(DW), .DEPTH(DEPTH), .AF_LEVEL(AF)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_last(s_last), .s_data(s_data), .s_ready(s_ready),
    .fifo_wren(fifo_wren), .fifo_wd(fifo_wd), .fifo_full(fifo_full),
    .fifo_empty(fifo_empty), .fifo_rd(fifo_rd), .fifo_rden(fifo_rden),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_id(m_id),
    .level(level), .almost_full(almost_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural storage FIFO owned by the "parent".
  logic [IDW+DW-1:0] mem [DEPTH];
  logic [1:0]        wp, rp;
  int                cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp <= '0; rp <= '0; cnt <= 0;
    end else begin
      if (fifo_wren) begin mem[wp] <= fifo_wd; wp <= wp + 2'd1; end
      if (fifo_rden) rp <= rp + 2'd1;
      cnt <= cnt + (fifo_wren ? 1 : 0) - (fifo_rden ? 1 : 0);
    end
  end
  assign fifo_full  = (cnt == DEPTH);
  assign fifo_empty = (cnt == 0);
  assign fifo_rd    = mem[rp];

  typedef struct {
    logic [3:0] sv;
    logic [3:0] sl;
    logic       mr;
    logic [3:0] er;
    logic       ew;
    int         lev;
    logic       mv;
  } vec_t;

  vec_t              tbl[$];
  logic [IDW+DW-1:0] sb[$];
  int                beat[NREQ];
  int                errors = 0;
  int                checks = 0;

  function automatic vec_t row(logic [3:0] sv, logic [3:0] sl, logic mr,
                               logic [3:0] er, logic ew, int lev, logic mv);
    vec_t v;
    v.sv = sv; v.sl = sl; v.mr = mr; v.er = er; v.ew = ew; v.lev = lev; v.mv = mv;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Compare any read happening at the coming edge, then advance one cycle.
  task automatic tick();
    logic [IDW+DW-1:0] e;
    if (m_valid && m_ready) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb_underflow: read id=%0d data=%0h with nothing expected", m_id, m_data);
      end else begin
        e = sb.pop_front();
        chk("read_word", {30'd0, m_id, m_data}, {30'd0, e});
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic apply_row(input vec_t v, input string tag);
    s_valid = v.sv;
    s_last  = v.sl;
    m_ready = v.mr;
    for (int i = 0; i < NREQ; i++)
      s_data[i*DW +: DW] = 32'hC0DE_0000 | (32'(i) << 12) | 32'(beat[i]);
    #2;
    chk({tag, ".s_ready"},     64'(s_ready),     64'(v.er));
    chk({tag, ".fifo_wren"},   64'(fifo_wren),   64'(v.ew));
    chk({tag, ".level"},       64'(level),       64'(v.lev));
    chk({tag, ".almost_full"}, 64'(almost_full), 64'(v.lev >= AF));
    chk({tag, ".m_valid"},     64'(m_valid),     64'(v.mv));
    chk({tag, ".fifo_rden"},   64'(fifo_rden),   64'(v.mv & v.mr));
    for (int i = 0; i < NREQ; i++) begin
      if (v.er[i]) begin
        sb.push_back({IDW'(i), s_data[i*DW +: DW]});
        beat[i]++;
      end
    end
    tick();
  endtask

  initial begin
    for (int i = 0; i < NREQ; i++) beat[i] = 0;
    rst_n = 1'b0; s_valid = 4'hF; s_last = 4'hF; m_ready = 1'b1; s_data = '0;
    #2;
    chk("reset.s_ready",   64'(s_ready),   64'd0);
    chk("reset.fifo_wren", 64'(fifo_wren), 64'd0);
    chk("reset.fifo_rden", 64'(fifo_rden), 64'd0);
    chk("reset.m_valid",   64'(m_valid),   64'd0);
    chk("reset.level",     64'(level),     64'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Round robin with single-beat bursts, then drain.
    tbl.push_back(row(4'hF, 4'hF, 1, 4'b0001, 1, 0, 0));
    tbl.push_back(row(4'hF, 4'hF, 1, 4'b0010, 1, 1, 1));
    tbl.push_back(row(4'hF, 4'hF, 1, 4'b0100, 1, 1, 1));
    tbl.push_back(row(4'hF, 4'hF, 1, 4'b1000, 1, 1, 1));
    tbl.push_back(row(4'hF, 4'hF, 1, 4'b0001, 1, 1, 1));
    tbl.push_back(row(4'h0, 4'h0, 1, 4'b0000, 0, 1, 1));
    tbl.push_back(row(4'h0, 4'h0, 1, 4'b0000, 0, 0, 0));
    // Producer 1 three-beat burst with a gap; producer 2 waits until it ends.
    tbl.push_back(row(4'b0110, 4'b0100, 1, 4'b0010, 1, 0, 0));
    tbl.push_back(row(4'b0100, 4'b0100, 1, 4'b0000, 0, 1, 1));
    tbl.push_back(row(4'b0110, 4'b0100, 1, 4'b0010, 1, 0, 0));
    tbl.push_back(row(4'b0110, 4'b0110, 1, 4'b0010, 1, 1, 1));
    tbl.push_back(row(4'b0100, 4'b0100, 1, 4'b0100, 1, 1, 1));
    tbl.push_back(row(4'h0, 4'h0, 1, 4'b0000, 0, 1, 1));
    tbl.push_back(row(4'h0, 4'h0, 1, 4'b0000, 0, 0, 0));
    // Consumer stalled: fill to full, almost_full from level 3, no write when full.
    tbl.push_back(row(4'hF, 4'hF, 0, 4'b1000, 1, 0, 0));
    tbl.push_back(row(4'hF, 4'hF, 0, 4'b0001, 1, 1, 1));
    tbl.push_back(row(4'hF, 4'hF, 0, 4'b0010, 1, 2, 1));
    tbl.push_back(row(4'hF, 4'hF, 0, 4'b0100, 1, 3, 1));
    tbl.push_back(row(4'hF, 4'hF, 0, 4'b0000, 0, 4, 1));
    tbl.push_back(row(4'hF, 4'hF, 0, 4'b0000, 0, 4, 1));
    // Full with a read in the same cycle: read only, the write lands next cycle.
    tbl.push_back(row(4'hF, 4'hF, 1, 4'b0000, 0, 4, 1));
    tbl.push_back(row(4'hF, 4'hF, 0, 4'b1000, 1, 3, 1));
    tbl.push_back(row(4'h0, 4'h0, 0, 4'b0000, 0, 4, 1));
    tbl.push_back(row(4'h0, 4'h0, 1, 4'b0000, 0, 4, 1));
    tbl.push_back(row(4'h0, 4'h0, 1, 4'b0000, 0, 3, 1));
    tbl.push_back(row(4'h0, 4'h0, 1, 4'b0000, 0, 2, 1));
    tbl.push_back(row(4'h0, 4'h0, 1, 4'b0000, 0, 1, 1));
    // Empty FIFO with a ready consumer: nothing read.
    tbl.push_back(row(4'h0, 4'h0, 1, 4'b0000, 0, 0, 0));
    tbl.push_back(row(4'h0, 4'h0, 1, 4'b0000, 0, 0, 0));

    for (int n = 0; n < tbl.size(); n++) apply_row(tbl[n], $sformatf("v%0d", n));

    // Reset in the middle of a locked burst with two words stored.
    apply_row(row(4'b0001, 4'b0000, 0, 4'b0001, 1, 0, 0), "rb0");
    apply_row(row(4'b0001, 4'b0000, 0, 4'b0001, 1, 1, 1), "rb1");
    s_valid = 4'hF; s_last = 4'h0; m_ready = 1'b1;
    rst_n = 1'b0;
    #2;
    chk("midrst.level",       64'(level),       64'd0);
    chk("midrst.s_ready",     64'(s_ready),     64'd0);
    chk("midrst.fifo_wren",   64'(fifo_wren),   64'd0);
    chk("midrst.m_valid",     64'(m_valid),     64'd0);
    chk("midrst.fifo_rden",   64'(fifo_rden),   64'd0);
    chk("midrst.almost_full", 64'(almost_full), 64'd0);
    sb.delete();
    tick();
    tick();
    rst_n = 1'b1;
    // Pointer back at 0 picks producer 0; then a non-owner is granted, so the lock is gone.
    apply_row(row(4'b0011, 4'b0011, 0, 4'b0001, 1, 0, 0), "ar0");
    apply_row(row(4'b0010, 4'b0010, 0, 4'b0010, 1, 1, 1), "ar1");
    apply_row(row(4'h0, 4'h0, 1, 4'b0000, 0, 2, 1), "ar2");
    apply_row(row(4'h0, 4'h0, 1, 4'b0000, 0, 1, 1), "ar3");
    apply_row(row(4'h0, 4'h0, 1, 4'b0000, 0, 0, 0), "ar4");
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
